// File: rtl/store_unit_ctrl_pkg.sv
// Shared RISC-V store definitions: store-control encodings, controller states
// and byte-lane size masks.
package riscv_pkg;

  localparam logic [2:0] SB = 3'd0;
  localparam logic [2:0] SH = 3'd1;
  localparam logic [2:0] SW = 3'd2;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  // Unknown encodings fall back to a byte store.
  function automatic logic [3:0] size_mask(input logic [2:0] ctrl);
    case (ctrl)
      SH:      size_mask = MASK_H;
      SW:      size_mask = MASK_W;
      default: size_mask = MASK_B;
    endcase
  endfunction

endpackage

// File: rtl/store_unit_ctrl_if.sv
// Store request and memory write-port bundle. misalign_err exists only when
// MISALIGNED_SPLIT_EN is undefined.
interface store_unit_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_data;
  logic [2:0]            req_ctrl;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  done;
  logic                  busy;
`ifndef MISALIGNED_SPLIT_EN
  logic                  misalign_err;
`endif

  modport master (
    output req_valid, req_addr, req_data, req_ctrl, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, busy
`ifndef MISALIGNED_SPLIT_EN
    , input misalign_err
`endif
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_ctrl, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, busy
`ifndef MISALIGNED_SPLIT_EN
    , output misalign_err
`endif
  );

endinterface

// File: rtl/store_unit_ctrl_lane_align.sv
// Combinational byte-lane alignment: places store data and strobes into an
// 8-byte window starting at the word-aligned address.
module store_lane_align
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]          off,
  input  logic [DATA_W-1:0]   data,
  input  logic [2:0]          ctrl,
  output logic [7:0]          strb8,
  output logic [2*DATA_W-1:0] data64,
  output logic                split
);

  always_comb begin
    strb8  = {4'b0000, size_mask(ctrl)} << off;
    data64 = {{DATA_W{1'b0}}, data} << {off, 3'b000};
    split  = |strb8[7:4];
  end

endmodule

// File: rtl/store_unit_ctrl.sv
// Store sequencer: drives one or two word-aligned write beats per store.
// MISALIGNED_SPLIT_EN enables two-beat word-crossing stores; otherwise they are rejected.
module store_unit_ctrl
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  store_unit_ctrl_if.slave   bus
);

  state_t                state, state_nxt;
  logic [7:0]            strb8;
  logic [2*DATA_W-1:0]   data64;
  logic                  split;
  logic                  accept;
  logic                  last_hs;
  logic                  split_p0;
  logic [ADDR_W-1:0]     addr_p0;
  logic [2*DATA_W-1:0]   data64_p0;
  logic [7:0]            strb8_p0;
  logic                  done_p1;

  store_lane_align #(.DATA_W(DATA_W)) u_align (
    .off    (bus.req_addr[1:0]),
    .data   (bus.req_data),
    .ctrl   (bus.req_ctrl),
    .strb8  (strb8),
    .data64 (data64),
    .split  (split)
  );

  assign accept   = bus.req_valid & (state == IDLE);
  assign split_p0 = |strb8_p0[7:4];
  assign last_hs  = bus.mem_ready &
                    (((state == BEAT0) & ~split_p0) | (state == BEAT1));

  // p0: request captured at acceptance, held for the whole store
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0   <= {bus.req_addr[ADDR_W-1:2], 2'b00};
      data64_p0 <= data64;
      strb8_p0  <= strb8;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
`ifdef MISALIGNED_SPLIT_EN
        if (accept) state_nxt = BEAT0;
`else
        if (accept && !split) state_nxt = BEAT0;
`endif
      end
      BEAT0:   if (bus.mem_ready) state_nxt = split_p0 ? BEAT1 : IDLE;
      BEAT1:   if (bus.mem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    bus.req_ready = (state == IDLE);
    bus.busy      = (state != IDLE);
    case (state)
      BEAT0: begin
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr_p0;
        bus.mem_wdata = data64_p0[DATA_W-1:0];
        bus.mem_wstrb = strb8_p0[3:0];
      end
      BEAT1: begin
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr_p0 + ADDR_W'(4);
        bus.mem_wdata = data64_p0[2*DATA_W-1:DATA_W];
        bus.mem_wstrb = strb8_p0[7:4];
      end
      default: ;
    endcase
  end

  // p1: completion pulse, one cycle after the final beat handshake
  always_ff @(posedge clk) begin
    if (reset) done_p1 <= 1'b0;
    else       done_p1 <= last_hs;
  end
  assign bus.done = done_p1;

`ifndef MISALIGNED_SPLIT_EN
  logic err_p1;
  always_ff @(posedge clk) begin
    if (reset) err_p1 <= 1'b0;
    else       err_p1 <= accept & split;
  end
  assign bus.misalign_err = err_p1;
`endif

endmodule

// File: tb/tb_store_unit_ctrl.sv
// Directed bench for store_unit_ctrl; covers both MISALIGNED_SPLIT_EN builds.
module tb_store_unit_ctrl;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  store_unit_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  store_unit_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_ctrl  = c;
    bus.req_addr  = a;
    bus.req_data  = d;
  endtask

  function automatic logic [68:0] beat();
    return {bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if (beat() !== {1'b0, 32'h0, 32'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_beat: got %h want %h", beat(), {1'b0, 32'h0, 32'h0, 4'h0});
    end
    n_cmp++;
    if ({bus.req_ready, bus.busy, bus.done} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 100", {bus.req_ready, bus.busy, bus.done});
    end
  endtask

  task automatic test_sw_aligned();
    drive_req(SW, 32'h100, 32'hDEADBEEF);
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if ({beat(), bus.req_ready} !== {1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL sw_beat: got %h want %h", {beat(), bus.req_ready},
               {1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0});
    end
    tick();
    n_cmp++;
    if ({bus.done, bus.req_ready, bus.mem_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL sw_done: got %b want 110", {bus.done, bus.req_ready, bus.mem_valid});
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_done_pulse: got %b want 0", bus.done);
    end
  endtask

  task automatic test_sb();
    drive_req(SB, 32'h203, 32'h000000A5);
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if (beat() !== {1'b1, 32'h200, 32'hA5000000, 4'h8}) begin
      n_fail++;
      $display("FAIL sb_beat: got %h want %h", beat(), {1'b1, 32'h200, 32'hA5000000, 4'h8});
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_done: got %b want 1", bus.done);
    end
    // undefined control encoding behaves as SB
    drive_req(3'd7, 32'h501, 32'hFFFFFF77);
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if (beat() !== {1'b1, 32'h500, 32'hFFFF7700, 4'h2}) begin
      n_fail++;
      $display("FAIL badctrl_beat: got %h want %h", beat(), {1'b1, 32'h500, 32'hFFFF7700, 4'h2});
    end
    tick();
    tick();
  endtask

`ifdef MISALIGNED_SPLIT_EN
  task automatic test_split_sh();
    drive_req(SH, 32'h303, 32'h00001234);
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if (beat() !== {1'b1, 32'h300, 32'h34000000, 4'h8}) begin
      n_fail++;
      $display("FAIL sh_beat0: got %h want %h", beat(), {1'b1, 32'h300, 32'h34000000, 4'h8});
    end
    tick();
    n_cmp++;
    if ({beat(), bus.done} !== {1'b1, 32'h304, 32'h00000012, 4'h1, 1'b0}) begin
      n_fail++;
      $display("FAIL sh_beat1: got %h want %h", {beat(), bus.done},
               {1'b1, 32'h304, 32'h00000012, 4'h1, 1'b0});
    end
    tick();
    n_cmp++;
    if ({bus.done, bus.mem_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL sh_done: got %b want 10", {bus.done, bus.mem_valid});
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL sh_done_once: got %b want 0", bus.done);
    end
  endtask

  task automatic test_stall();
    bus.mem_ready = 1'b0;
    drive_req(SW, 32'h1FE, 32'hAABBCCDD);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({beat(), bus.req_ready, bus.done} !== {1'b1, 32'h1FC, 32'hCCDD0000, 4'hC, 2'b00}) begin
        n_fail++;
        $display("FAIL stall_beat0[%0d]: got %h want %h", i, {beat(), bus.req_ready, bus.done},
                 {1'b1, 32'h1FC, 32'hCCDD0000, 4'hC, 2'b00});
      end
      if (i == 3) bus.mem_ready = 1'b1;
      tick();
    end
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({beat(), bus.req_ready, bus.done} !== {1'b1, 32'h200, 32'h0000AABB, 4'h3, 2'b00}) begin
        n_fail++;
        $display("FAIL stall_beat1[%0d]: got %h want %h", i, {beat(), bus.req_ready, bus.done},
                 {1'b1, 32'h200, 32'h0000AABB, 4'h3, 2'b00});
      end
      if (i == 3) bus.mem_ready = 1'b1;
      tick();
    end
    n_cmp++;
    if ({bus.done, bus.req_ready, bus.mem_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL stall_done: got %b want 110", {bus.done, bus.req_ready, bus.mem_valid});
    end
    tick();
  endtask
`else
  task automatic test_misalign();
    drive_req(SW, 32'h401, 32'h01020304);
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if ({bus.misalign_err, bus.mem_valid, bus.req_ready, bus.done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL misalign_pulse: got %b want 1010",
               {bus.misalign_err, bus.mem_valid, bus.req_ready, bus.done});
    end
    tick();
    n_cmp++;
    if ({bus.misalign_err, bus.mem_valid, bus.done} !== 3'b000) begin
      n_fail++;
      $display("FAIL misalign_once: got %b want 000", {bus.misalign_err, bus.mem_valid, bus.done});
    end
    drive_req(SW, 32'h404, 32'hCAFEF00D);
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if ({beat(), bus.misalign_err} !== {1'b1, 32'h404, 32'hCAFEF00D, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL misalign_next_beat: got %h want %h", {beat(), bus.misalign_err},
               {1'b1, 32'h404, 32'hCAFEF00D, 4'hF, 1'b0});
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_next_done: got %b want 1", bus.done);
    end
    tick();
  endtask
`endif

  task automatic test_back_to_back();
    drive_req(SW, 32'h10, 32'h00000001);
    tick();
    drive_req(SH, 32'h22, 32'h0000BEEF);
    n_cmp++;
    if (beat() !== {1'b1, 32'h10, 32'h00000001, 4'hF}) begin
      n_fail++;
      $display("FAIL b2b_beat_a: got %h want %h", beat(), {1'b1, 32'h10, 32'h00000001, 4'hF});
    end
    tick();
    n_cmp++;
    if ({bus.done, bus.req_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_done_a: got %b want 11", {bus.done, bus.req_ready});
    end
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if ({beat(), bus.done} !== {1'b1, 32'h20, 32'hBEEF0000, 4'hC, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_beat_b: got %h want %h", {beat(), bus.done},
               {1'b1, 32'h20, 32'hBEEF0000, 4'hC, 1'b0});
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done_b: got %b want 1", bus.done);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.mem_ready = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
    drive_req(SW, 32'h1FE, 32'h11223344);
    tick();
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    n_cmp++;
    if (beat() !== {1'b1, 32'h200, 32'h00001122, 4'h3}) begin
      n_fail++;
      $display("FAIL rstmid_pre: got %h want %h", beat(), {1'b1, 32'h200, 32'h00001122, 4'h3});
    end
`else
    drive_req(SW, 32'h600, 32'h11223344);
    tick();
    bus.req_valid = 1'b0;
    tick();
    n_cmp++;
    if (beat() !== {1'b1, 32'h600, 32'h11223344, 4'hF}) begin
      n_fail++;
      $display("FAIL rstmid_pre: got %h want %h", beat(), {1'b1, 32'h600, 32'h11223344, 4'hF});
    end
`endif
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({bus.mem_valid, bus.req_ready, bus.busy, bus.done} !== 4'b0100) begin
      n_fail++;
      $display("FAIL rstmid_state: got %b want 0100",
               {bus.mem_valid, bus.req_ready, bus.busy, bus.done});
    end
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    n_cmp++;
    if ({bus.mem_valid, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_nodone: got %b want 00", {bus.mem_valid, bus.done});
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_ctrl  = SB;
    bus.mem_ready = 1'b1;
    test_reset();
    test_sw_aligned();
    test_sb();
`ifdef MISALIGNED_SPLIT_EN
    test_split_sh();
    test_stall();
`else
    test_misalign();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
